// File: rtl/spi_slave_stream.sv
// SPI target with all four SPI modes, configurable word width and back-to-back
// words per chip-select frame. RX and TX words move over valid/ready streams.
// Underrun, overrun and frame-end events are reported as one-cycle pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame; sclk ignored; waiting for an armed cs_n fall
// ACTIVE  | frame running; sample/shift on normalised sclk edges
module spi_slave_stream #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL        = {DATA_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FL_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [FL_W-1:0]  FLUSH_LEN = FL_W'(SYNC_STAGES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_in_q, shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              frame_done_q, frame_done_d;
    // A frame may only start once cs_n has been seen high after reset, so a
    // cs_n held low through reset cannot open a frame halfway through.
    logic              armed_q, armed_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic              sclk_s, cs_s, mosi_s;
    logic              nclk, nclk_prev;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              cs_fall, cs_rise;
    logic              tx_load;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_word;

    // Pin synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign nclk        = sclk_s ^ cpol_q;
    assign nclk_prev   = sclk_prev_q ^ cpol_q;
    assign lead_edge   = nclk & ~nclk_prev;
    assign trail_edge  = ~nclk & nclk_prev;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;

    assign load_word = tx_full_q ? tx_buf_q : FILL;
    assign rx_word   = {shift_in_q[DATA_W-2:0], mosi_s};

    // Frame FSM, shift datapath and stream handshakes.
    always_comb begin
        state_d       = state_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        bit_cnt_d     = bit_cnt_q;
        shift_in_d    = shift_in_q;
        shift_out_d   = shift_out_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_underrun_d = 1'b0;
        rx_overrun_d  = 1'b0;
        frame_done_d  = 1'b0;
        tx_load       = 1'b0;
        flush_cnt_d   = (flush_cnt_q == '0) ? flush_cnt_q : flush_cnt_q - 1'b1;
        armed_d       = armed_q | ((flush_cnt_q == '0) & cs_s);

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = ST_ACTIVE;
                    cpol_d    = mode_i[1];
                    cpha_d    = mode_i[0];
                    bit_cnt_d = '0;
                    if (!mode_i[0]) begin
                        tx_load     = 1'b1;
                        shift_out_d = load_word;
                    end else begin
                        shift_out_d = FILL;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    if (sample_edge) begin
                        shift_in_d = rx_word;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            if (rx_valid_q && !rx_ready_i) begin
                                rx_overrun_d = 1'b1;
                            end else begin
                                rx_data_d  = rx_word;
                                rx_valid_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (bit_cnt_q == '0) begin
                            tx_load     = 1'b1;
                            shift_out_d = load_word;
                        end else begin
                            shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The load sees the pre-write buffer state, so a same-cycle write
        // survives for the following load.
        if (tx_load) begin
            if (tx_full_q) begin
                tx_full_d = 1'b0;
            end else begin
                tx_underrun_d = 1'b1;
            end
        end
        if (tx_valid_i && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data_i;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            bit_cnt_q     <= '0;
            shift_in_q    <= '0;
            shift_out_q   <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            armed_q       <= 1'b0;
            flush_cnt_q   <= FLUSH_LEN;
        end else begin
            state_q       <= state_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_in_q    <= shift_in_d;
            shift_out_q   <= shift_out_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overrun_q  <= rx_overrun_d;
            frame_done_q  <= frame_done_d;
            armed_q       <= armed_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign busy_o        = (state_q == ST_ACTIVE);
    assign miso_oe_o     = busy_o;
    assign miso_o        = busy_o & shift_out_q[DATA_W-1];
    assign tx_ready_o    = ~tx_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = tx_underrun_q;
    assign rx_overrun_o  = rx_overrun_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: an 8-bit and a 16-bit instance driven by a
// behavioural SPI master, with stream feeders/recorders and a word-level model.
module tb_spi_slave_stream;

    localparam int H = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [1:0] mode = 2'b00;

    logic       cs_n8 = 1'b1;
    logic       miso8, miso_oe8, tx_ready8, rx_valid8, tx_underrun8, rx_overrun8, frame_done8, busy8;
    logic       tx_valid8 = 1'b0;
    logic       rx_ready8 = 1'b1;
    logic [7:0] tx_data8 = 8'h00;
    logic [7:0] rx_data8;

    logic        cs_n16 = 1'b1;
    logic        miso16, miso_oe16, tx_ready16, rx_valid16, tx_underrun16, rx_overrun16, frame_done16, busy16;
    logic        tx_valid16 = 1'b0;
    logic        rx_ready16 = 1'b1;
    logic [15:0] tx_data16 = 16'h0000;
    logic [15:0] rx_data16;

    spi_slave_stream #(.DATA_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n8), .mosi_i(mosi),
        .miso_o(miso8), .miso_oe_o(miso_oe8), .mode_i(mode),
        .tx_data_i(tx_data8), .tx_valid_i(tx_valid8), .tx_ready_o(tx_ready8),
        .rx_data_o(rx_data8), .rx_valid_o(rx_valid8), .rx_ready_i(rx_ready8),
        .tx_underrun_o(tx_underrun8), .rx_overrun_o(rx_overrun8),
        .frame_done_o(frame_done8), .busy_o(busy8)
    );

    spi_slave_stream #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n16), .mosi_i(mosi),
        .miso_o(miso16), .miso_oe_o(miso_oe16), .mode_i(mode),
        .tx_data_i(tx_data16), .tx_valid_i(tx_valid16), .tx_ready_o(tx_ready16),
        .rx_data_o(rx_data16), .rx_valid_o(rx_valid16), .rx_ready_i(rx_ready16),
        .tx_underrun_o(tx_underrun16), .rx_overrun_o(rx_overrun16),
        .frame_done_o(frame_done16), .busy_o(busy16)
    );

    // Event counters and stream recorders (written only by the monitor)
    int          und8 = 0, ovr8 = 0, fd8 = 0, busy_cyc8 = 0;
    int          und16 = 0, ovr16 = 0, fd16 = 0;
    logic [7:0]  rx_mem [256];
    int          rx_wr = 0;
    logic [15:0] rx16_mem [16];
    int          rx16_wr = 0;
    int          tx_rd = 0;
    logic        prv_rv8 = 1'b0, prv_rr8 = 1'b0, prv_tr8 = 1'b0;
    logic [7:0]  prv_rd8 = 8'h00;
    logic        prv_rv16 = 1'b0;
    logic [15:0] prv_rd16 = 16'h0000;

    // TX words queued by the main process
    logic [7:0]  tx_mem [256];
    int          tx_wr = 0;

    int n_checks = 0;
    int n_errors = 0;

    always @(negedge clk) begin
        if (tx_underrun8) und8++;
        if (rx_overrun8)  ovr8++;
        if (frame_done8)  fd8++;
        if (busy8)        busy_cyc8++;
        if (tx_underrun16) und16++;
        if (rx_overrun16)  ovr16++;
        if (frame_done16)  fd16++;
        if (prv_rv8 && prv_rr8 && rx_wr < 256) begin
            rx_mem[rx_wr] = prv_rd8;
            rx_wr++;
        end
        prv_rv8 = rx_valid8; prv_rr8 = rx_ready8; prv_rd8 = rx_data8;
        if (prv_rv16 && rx16_wr < 16) begin
            rx16_mem[rx16_wr] = prv_rd16;
            rx16_wr++;
        end
        prv_rv16 = rx_valid16; prv_rd16 = rx_data16;
        if (tx_valid8 && prv_tr8) tx_rd++;
        if (tx_rd < tx_wr) begin
            tx_valid8 = 1'b1;
            tx_data8  = tx_mem[tx_rd];
        end else begin
            tx_valid8 = 1'b0;
        end
        prv_tr8 = tx_ready8;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SPI master
    logic [15:0] m_words [8];
    logic [15:0] cap_words [8];
    int          ready_bit = -1;

    task automatic post_sample(input int b);
        repeat (2) @(negedge clk);
        if (b == ready_bit) rx_ready8 = 1'b1;
        repeat (H - 2) @(negedge clk);
    endtask

    task automatic spi_frame(input bit sel16, input logic [1:0] md, input int nbits);
        int   w;
        logic bit_v;
        w = sel16 ? 16 : 8;
        mode = md;
        sclk = md[1];
        for (int k = 0; k < 8; k++) cap_words[k] = 16'h0000;
        repeat (4) @(negedge clk);
        if (sel16) cs_n16 = 1'b0; else cs_n8 = 1'b0;
        repeat (H) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            bit_v = m_words[b / w][w - 1 - (b % w)];
            if (!md[0]) begin
                mosi = bit_v;
                repeat (H) @(negedge clk);
                cap_words[b / w][w - 1 - (b % w)] = sel16 ? miso16 : miso8;
                sclk = ~sclk;
                post_sample(b);
                sclk = ~sclk;
            end else begin
                repeat (H) @(negedge clk);
                sclk = ~sclk;
                mosi = bit_v;
                repeat (H) @(negedge clk);
                cap_words[b / w][w - 1 - (b % w)] = sel16 ? miso16 : miso8;
                sclk = ~sclk;
                post_sample(b);
            end
        end
        repeat (H) @(negedge clk);
        if (sel16) cs_n16 = 1'b1; else cs_n8 = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_mem[tx_wr] = d;
        tx_wr++;
    endtask

    // Directed vectors: word k of a 24-bit field lives in bits [23-8k -: 8]
    typedef struct packed {
        logic [1:0]  md;
        logic [1:0]  nw;
        logic [1:0]  ntx;
        logic [23:0] tx;
        logic [23:0] mo;
        logic [23:0] exp_miso;
        logic [1:0]  exp_und;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int u0, f0, o0, r0, b0;
        int nw, ntx, loads, exp_und;
        logic [1:0] md;
        logic [7:0] rt [4];
        logic [7:0] rm [4];

        vecs[0] = '{2'b00, 2'd3, 2'd3, 24'h0180FF, 24'h0180FF, 24'h0180FF, 2'd1};
        vecs[1] = '{2'b01, 2'd3, 2'd3, 24'h0180FF, 24'h0180FF, 24'h0180FF, 2'd0};
        vecs[2] = '{2'b10, 2'd3, 2'd3, 24'h0180FF, 24'h0180FF, 24'h0180FF, 2'd1};
        vecs[3] = '{2'b11, 2'd3, 2'd3, 24'h0180FF, 24'h0180FF, 24'h0180FF, 2'd0};
        vecs[4] = '{2'b01, 2'd2, 2'd0, 24'h000000, 24'h5AC300, 24'hFFFF00, 2'd2};
        vecs[5] = '{2'b00, 2'd1, 2'd0, 24'h000000, 24'h3C0000, 24'hFF0000, 2'd2};
        vecs[6] = '{2'b11, 2'd2, 2'd1, 24'h770000, 24'hA55A00, 24'h77FF00, 2'd1};
        vecs[7] = '{2'b10, 2'd2, 2'd3, 24'hC0FFEE, 24'h123456, 24'hC0FF00, 2'd0};

        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Reset state
        check("rst_miso",     32'(miso8), 32'd0);
        check("rst_miso_oe",  32'(miso_oe8), 32'd0);
        check("rst_busy",     32'(busy8), 32'd0);
        check("rst_tx_ready", 32'(tx_ready8), 32'd1);
        check("rst_rx_valid", 32'(rx_valid8), 32'd0);
        check("rst_rx_data",  32'(rx_data8), 32'd0);
        check("rst_pulses",   32'({tx_underrun8, rx_overrun8, frame_done8}), 32'd0);
        check("rst_tx_ready16", 32'(tx_ready16), 32'd1);

        // Mode 1 single byte, consumer not ready
        rx_ready8 = 1'b0;
        f0 = fd8; u0 = und8;
        push_tx(8'hA5);
        m_words[0] = 16'h003C;
        spi_frame(1'b0, 2'b01, 8);
        check("m1_miso", 32'(cap_words[0][7:0]), 32'h A5);
        check("m1_rx_valid", 32'(rx_valid8), 32'd1);
        check("m1_rx_data", 32'(rx_data8), 32'h3C);
        check("m1_frame_done", 32'(fd8 - f0), 32'd1);
        check("m1_underrun", 32'(und8 - u0), 32'd0);
        rx_ready8 = 1'b1;
        repeat (4) @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            u0 = und8; f0 = fd8; o0 = ovr8; r0 = rx_wr;
            for (int k = 0; k < int'(vecs[i].ntx); k++) push_tx(vecs[i].tx[23 - 8*k -: 8]);
            for (int k = 0; k < 3; k++) m_words[k] = {8'h00, vecs[i].mo[23 - 8*k -: 8]};
            spi_frame(1'b0, vecs[i].md, 8 * int'(vecs[i].nw));
            check($sformatf("vec%0d_frame_done", i), 32'(fd8 - f0), 32'd1);
            check($sformatf("vec%0d_underrun", i), 32'(und8 - u0), 32'(vecs[i].exp_und));
            check($sformatf("vec%0d_overrun", i), 32'(ovr8 - o0), 32'd0);
            check($sformatf("vec%0d_rx_count", i), 32'(rx_wr - r0), 32'(vecs[i].nw));
            for (int k = 0; k < int'(vecs[i].nw); k++) begin
                check($sformatf("vec%0d_rx%0d", i, k), 32'(rx_mem[(r0 + k) % 256]), 32'(vecs[i].mo[23 - 8*k -: 8]));
                check($sformatf("vec%0d_miso%0d", i, k), 32'(cap_words[k][7:0]), 32'(vecs[i].exp_miso[23 - 8*k -: 8]));
            end
        end

        // Overrun: two words with consumer stalled
        rx_ready8 = 1'b0;
        o0 = ovr8;
        m_words[0] = 16'h0011; m_words[1] = 16'h0022;
        spi_frame(1'b0, 2'b01, 16);
        check("ovr_rx_data", 32'(rx_data8), 32'h11);
        check("ovr_rx_valid", 32'(rx_valid8), 32'd1);
        check("ovr_pulses", 32'(ovr8 - o0), 32'd1);
        // Third word: consumer becomes ready in the completion cycle
        o0 = ovr8; r0 = rx_wr;
        ready_bit = 7;
        m_words[0] = 16'h0033;
        spi_frame(1'b0, 2'b01, 8);
        ready_bit = -1;
        rx_ready8 = 1'b1;
        check("ovr3_no_overrun", 32'(ovr8 - o0), 32'd0);
        check("ovr3_rx_count", 32'(rx_wr - r0), 32'd2);
        check("ovr3_first", 32'(rx_mem[r0 % 256]), 32'h11);
        check("ovr3_second", 32'(rx_mem[(r0 + 1) % 256]), 32'h33);

        // Partial word then a clean frame
        f0 = fd8; r0 = rx_wr;
        m_words[0] = 16'h00F8;
        spi_frame(1'b0, 2'b01, 5);
        check("part_frame_done", 32'(fd8 - f0), 32'd1);
        check("part_rx_count", 32'(rx_wr - r0), 32'd0);
        check("part_rx_valid", 32'(rx_valid8), 32'd0);
        m_words[0] = 16'h0096;
        spi_frame(1'b0, 2'b01, 8);
        check("part_next_count", 32'(rx_wr - r0), 32'd1);
        check("part_next_rx", 32'(rx_mem[r0 % 256]), 32'h96);

        // Mid-frame reset with cs_n held low
        mode = 2'b00; sclk = 1'b0;
        repeat (4) @(negedge clk);
        cs_n8 = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sclk = ~sclk;
            repeat (H) @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(busy8), 32'd0);
        check("mrst_miso_oe", 32'(miso_oe8), 32'd0);
        check("mrst_miso", 32'(miso8), 32'd0);
        check("mrst_tx_ready", 32'(tx_ready8), 32'd1);
        check("mrst_rx_valid", 32'(rx_valid8), 32'd0);
        b0 = busy_cyc8; r0 = rx_wr; f0 = fd8;
        for (int k = 0; k < 16; k++) begin
            sclk = ~sclk;
            mosi = ~mosi;
            repeat (H) @(negedge clk);
        end
        check("mrst_no_busy", 32'(busy_cyc8 - b0), 32'd0);
        check("mrst_no_rx", 32'(rx_wr - r0), 32'd0);
        cs_n8 = 1'b1;
        repeat (3 * H) @(negedge clk);
        check("mrst_no_frame_done", 32'(fd8 - f0), 32'd0);
        m_words[0] = 16'h005C;
        spi_frame(1'b0, 2'b00, 8);
        check("mrst_after_rx", 32'(rx_mem[r0 % 256]), 32'h5C);
        check("mrst_after_fd", 32'(fd8 - f0), 32'd1);

        // Randomised frames against a word-level model
        for (int t = 0; t < 12; t++) begin
            md    = 2'($urandom_range(0, 3));
            nw    = $urandom_range(1, 3);
            loads = nw + (md[0] ? 0 : 1);
            ntx   = $urandom_range(0, loads);
            exp_und = loads - ntx;
            for (int k = 0; k < 4; k++) begin
                rt[k] = 8'($urandom);
                rm[k] = 8'($urandom);
            end
            u0 = und8; r0 = rx_wr; f0 = fd8;
            for (int k = 0; k < ntx; k++) push_tx(rt[k]);
            for (int k = 0; k < 4; k++) m_words[k] = {8'h00, rm[k]};
            spi_frame(1'b0, md, 8 * nw);
            check($sformatf("rnd%0d_underrun", t), 32'(und8 - u0), 32'(exp_und));
            check($sformatf("rnd%0d_rx_count", t), 32'(rx_wr - r0), 32'(nw));
            check($sformatf("rnd%0d_fd", t), 32'(fd8 - f0), 32'd1);
            for (int k = 0; k < nw; k++) begin
                check($sformatf("rnd%0d_rx%0d", t, k), 32'(rx_mem[(r0 + k) % 256]), 32'(rm[k]));
                check($sformatf("rnd%0d_miso%0d", t, k), 32'(cap_words[k][7:0]),
                      32'((k < ntx) ? rt[k] : 8'hFF));
            end
        end

        // 16-bit instance, mode 0
        tx_data16 = 16'hBEEF;
        tx_valid16 = 1'b1;
        @(negedge clk);
        tx_valid16 = 1'b0;
        check("w16_tx_ready_after_write", 32'(tx_ready16), 32'd0);
        f0 = fd16;
        m_words[0] = 16'hBEEF;
        spi_frame(1'b1, 2'b00, 16);
        check("w16_msb_first", 32'(cap_words[0][15]), 32'd1);
        check("w16_miso", 32'(cap_words[0]), 32'hBEEF);
        check("w16_rx_count", 32'(rx16_wr), 32'd1);
        check("w16_rx", 32'(rx16_mem[0]), 32'hBEEF);
        check("w16_fd", 32'(fd16 - f0), 32'd1);
        check("w16_underrun", 32'(und16), 32'd1);
        check("w16_overrun", 32'(ovr16), 32'd0);
        check("w16_idle", 32'({busy16, miso_oe16}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_stream.md
# spi_slave_stream

Parametrised SPI target that replaces the fixed 8-bit, Mode-1-only, loop-back SPI slave. It supports all four SPI modes (selected per frame), a configurable word width, and back-to-back words inside one chip-select frame. Received and transmitted words move over valid/ready streams, so the block sits between the MCU-facing SPI pins and the on-chip register/bus fabric. Underrun, overrun and frame-end events are reported as flags.

## Interface
Parameters:
- DATA_W, 8, word width in bits; must be 4 or more.
- SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi; must be 2 or more.
- FILL, all-ones (DATA_W bits), word shifted out when no TX word is available.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  serial data in, asynchronous.
- miso  out  1  serial data out; driven 0 while miso_oe=0.
- miso_oe  out  1  pad output enable; 1 while a frame is active.
- mode  in  2  {CPOL, CPHA}; latched at frame start.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX holding register is empty.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts rx_data.
- tx_underrun  out  1  one-cycle pulse: FILL was loaded in place of a TX word.
- rx_overrun  out  1  one-cycle pulse: a received word was dropped.
- frame_done  out  1  one-cycle pulse when cs_n deasserts.
- busy  out  1  a frame is active.

## Operation
- **Synchronisers.** sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the last two stages. On reset, the cs_n chain loads 1 and the others load 0.
- **Normalised clock.** nclk = sync_sclk XOR CPOL_latched. The leading edge is the rising edge of nclk; the trailing edge is its falling edge.
- **Sample and shift edges.** CPHA=0 samples on the leading edge and shifts on the trailing edge. CPHA=1 shifts on the leading edge and samples on the trailing edge.
- **State machine.**
  - IDLE to ACTIVE on a synchronised cs_n falling edge. On this transition: latch mode, bit_cnt=0, shift_out = (CPHA=0 ? loaded TX word : FILL).
  - ACTIVE to IDLE on a synchronised cs_n rising edge. On this transition: pulse frame_done and discard any partial RX word.
  - Leaving reset always goes to IDLE. If cs_n is already low at that point, no frame runs until cs_n goes high and then falls again.
- **Sample edge.** shift_in = {shift_in[DATA_W-2:0], mosi_sync}, then bit_cnt increments and wraps at DATA_W-1 back to 0.
  - When bit_cnt was DATA_W-1, the word is complete:
    - If rx_valid=1 and rx_ready=0 in that cycle, keep the old rx_data and pulse rx_overrun.
    - Otherwise rx_data = the new word and rx_valid=1.
- **Shift edge.**
  - If bit_cnt=0, this is a word boundary: load the next TX word.
  - Otherwise shift_out shifts left with 0 fill.
- **TX word load.**
  - TX buffer full: take the buffered word and mark the buffer empty.
  - TX buffer empty: take FILL and pulse tx_underrun.
  - For CPHA=0, the word loaded on the trailing edge after the last word of a frame is consumed and discarded when cs_n rises.
- **TX buffer handshake.**
  - Write: tx_valid && tx_ready, with tx_ready = !full.
  - A load and a write in the same cycle see the pre-write state, so the written word is kept for the next load.
- **RX handshake.** rx_valid clears on rx_valid && rx_ready, unless a new word completes in the same cycle.
- **Outputs.** miso = shift_out[DATA_W-1] while ACTIVE, otherwise 0. miso_oe = busy = ACTIVE.
- **Inactive edges.** sclk edges outside ACTIVE are ignored.

## Timing
- **Reset values.** miso=0, miso_oe=0, busy=0, tx_ready=1, rx_valid=0, rx_data=0, tx_underrun=0, rx_overrun=0, frame_done=0. Internal state: shift registers 0, TX buffer empty.
- **Pin-to-detect latency.** SYNC_STAGES+1 clk cycles.
- **Status latency.** rx_valid rises 1 clk after the detected sample edge of the last bit. miso updates 1 clk after the detected shift edge.
- **sclk limits.** sclk high and low times must each be at least SYNC_STAGES+2 clk cycles. At 100 MHz with SYNC_STAGES=2, sclk must be 12.5 MHz or lower.
- **cs_n timing.** Setup from cs_n falling to the first sclk edge, and hold from the last sclk edge to cs_n rising, must each be at least SYNC_STAGES+2 clk cycles.
- **Mode changes.** Changes on mode during ACTIVE have no effect until the next frame.

## Test plan
- **Mode 1, single byte.** Reset, tx_data=8'hA5 written, mode=2'b01, one frame carrying MOSI 8'h3C. Expected: MISO bits = A5, rx_data=8'h3C, rx_valid=1, frame_done pulses once.
- **All four modes, burst.** For each mode, a 3-word burst of 8'h01, 8'h80, 8'hFF with tx_data refilled on every tx_ready. Expected: RX sequence matches and MISO carries the written words in order.
- **Underrun.** No TX word written before the frame. Expected: MISO = 8'hFF and tx_underrun pulses exactly once per word.
- **Overrun.** rx_ready held at 0 across two received words, 8'h11 then 8'h22. Expected: rx_data=8'h11 and rx_overrun pulses once. Then raise rx_ready on the completion cycle of a third word; expected: the new word is accepted with no overrun.
- **Partial word and mid-frame reset.**
  - cs_n rises after 5 bits. Expected: no rx_valid, bit_cnt restarts on the next frame.
  - rst asserted mid-frame with cs_n held low. Expected: outputs at reset values, and no activity until cs_n rises and then falls again.
- **DATA_W=16, CPHA=0.** Word 16'hBEEF. Expected: MSB on miso before the first sclk edge, and 16'hBEEF received.
